// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous data RAM
// between two cores. It serves one transaction at a time and answers with a one-cycle ready pulse.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ready0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ready1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              last
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              g_q;
  logic              last_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              ready0_q, ready1_q;

  logic              cand0, cand1;
  logic              grant_d;
  logic              gnt_idx_d;
  logic              gnt_wr_d;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic [DATA_W-1:0] gnt_wdata_d;

  // The core being answered in RESP still holds its request, so it is not a candidate then.
  always_comb begin
    cand0       = (rd0 | wr0) && !(state_q == S_RESP && g_q == 1'b0);
    cand1       = (rd1 | wr1) && !(state_q == S_RESP && g_q == 1'b1);
    grant_d     = (state_q == S_IDLE || state_q == S_RESP) && (cand0 || cand1);
    gnt_idx_d   = (cand0 && cand1) ? ~last_q : cand1;
    gnt_wr_d    = gnt_idx_d ? wr1 : wr0;
    gnt_addr_d  = gnt_idx_d ? addr1 : addr0;
    gnt_wdata_d = gnt_idx_d ? wdata1 : wdata0;
    state_d     = state_q;
    case (state_q)
      S_IDLE:   state_d = grant_d ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_RESP;
      S_RESP:   state_d = grant_d ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= 1'b0;
      last_q      <= 1'b1;
      op_wr_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      // Strobes are launched on the grant edge so they are high exactly during ACCESS.
      if (grant_d) begin
        g_q         <= gnt_idx_d;
        last_q      <= gnt_idx_d;
        op_wr_q     <= gnt_wr_d;
        mem_addr_q  <= gnt_addr_d;
        mem_wdata_q <= gnt_wdata_d;
        mem_wr_q    <= gnt_wr_d;
        mem_rd_q    <= ~gnt_wr_d;
      end
      if (state_q == S_WAIT) begin
        if (g_q) begin
          ready1_q <= 1'b1;
          if (!op_wr_q) rdata1_q <= mem_rdata;
        end else begin
          ready0_q <= 1'b1;
          if (!op_wr_q) rdata0_q <= mem_rdata;
        end
      end
    end
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ready0    = ready0_q;
  assign ready1    = ready1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign last      = last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized two-core run scored against a transaction-level memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic [15:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata;
  logic        last;

  int total = 0;
  int bad   = 0;

  bit [15:0] ram [0:65535];
  bit [15:0] shadow [0:7];
  logic [15:0] lastRd [0:1];
  bit randDone = 1'b0;

  typedef struct {
    int          core;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        expMemRd;
    logic        expMemWr;
    logic [15:0] expRdata0;
    logic [15:0] expRdata1;
  } vec_t;

  vec_t vecs [10];

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ready0(ready0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ready1(ready1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .last(last)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic setReq(input int k, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (k == 0) begin
      rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // One isolated transaction from IDLE; caller is positioned at a negedge.
  task automatic applyStimulus(input vec_t v);
    setReq(v.core, v.rd, v.wr, v.addr, v.wdata);
    @(negedge clk);
    checkOutput("access_mem_rd", mem_rd, v.expMemRd);
    checkOutput("access_mem_wr", mem_wr, v.expMemWr);
    checkOutput("access_mem_addr", mem_addr, v.addr);
    if (v.expMemWr) checkOutput("access_mem_wdata", mem_wdata, v.wdata);
    checkOutput("access_ready", {ready0, ready1}, 0);
    checkOutput("access_last", last, v.core);
    @(negedge clk);
    checkOutput("wait_strobes", {mem_rd, mem_wr}, 0);
    @(negedge clk);
    checkOutput("resp_ready0", ready0, (v.core == 0));
    checkOutput("resp_ready1", ready1, (v.core == 1));
    checkOutput("resp_rdata0", rdata0, v.expRdata0);
    checkOutput("resp_rdata1", rdata1, v.expRdata1);
    setReq(v.core, 1'b0, 1'b0, v.addr, v.wdata);
    @(negedge clk);
    checkOutput("after_ready", {ready0, ready1}, 0);
  endtask

  // Random core agent: holds each request until its ready, then scores it against the shadow memory.
  task automatic coreRun(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int          idle;
      int          op;
      int          idx;
      int          waited;
      int          otherDone;
      logic        r, w, seen, myReady, otherReady;
      logic [15:0] d, myRdata;
      idle = $urandom_range(0, 3);
      repeat (idle) @(negedge clk);
      op  = $urandom_range(0, 2);
      idx = $urandom_range(0, 7);
      d   = 16'($urandom);
      r   = (op != 1);
      w   = (op != 0);
      setReq(k, r, w, 16'h0040 + 16'(idx), d);
      waited = 0;
      otherDone = 0;
      seen = 1'b0;
      while (!seen && waited < 20) begin
        @(negedge clk);
        waited++;
        myReady    = (k == 0) ? ready0 : ready1;
        otherReady = (k == 0) ? ready1 : ready0;
        myRdata    = (k == 0) ? rdata0 : rdata1;
        if (myReady) begin
          seen = 1'b1;
          if (w) begin
            checkOutput("rand_write_keeps_rdata", myRdata, lastRd[k]);
            shadow[idx] = d;
          end else begin
            checkOutput("rand_read_data", myRdata, shadow[idx]);
            lastRd[k] = shadow[idx];
          end
          checkOutput("rand_latency", (waited >= 3 && waited <= 6), 1);
          checkOutput("rand_starvation", (otherDone <= 1), 1);
        end else if (otherReady) begin
          otherDone++;
        end
      end
      if (!seen) checkOutput("rand_timeout", 0, 1);
      setReq(k, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    int readCount;
    int n;
    rst = 1'b1;
    setReq(0, 1'b0, 1'b0, 16'h0, 16'h0);
    setReq(1, 1'b0, 1'b0, 16'h0, 16'h0);
    vecs[0] = '{0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
    vecs[2] = '{0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'hBEEF};
    vecs[4] = '{1, 1'b0, 1'b1, 16'hFFFF, 16'h00A5, 1'b0, 1'b1, 16'h1234, 16'hBEEF};
    vecs[5] = '{1, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h00A5};
    vecs[6] = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h00A5};
    vecs[7] = '{0, 1'b0, 1'b1, 16'h0001, 16'hAAAA, 1'b0, 1'b1, 16'hBEEF, 16'h00A5};
    vecs[8] = '{1, 1'b0, 1'b1, 16'h0002, 16'h5555, 1'b0, 1'b1, 16'hBEEF, 16'h00A5};
    vecs[9] = '{1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'hAAAA};

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {rdata0, rdata1, mem_addr, mem_wdata, mem_rd, mem_wr, ready0, ready1}, 0);
    checkOutput("reset_last", last, 1);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    checkOutput("ram_rdwr_write", ram[16'h0020], 16'h1234);
    checkOutput("ram_wrap_addr", ram[16'hFFFF], 16'h00A5);

    $display("[TB] request held through own ready");
    readCount = 0;
    setReq(0, 1'b1, 1'b0, 16'h0002, 16'h0);
    repeat (3) begin
      @(negedge clk);
      readCount += int'(mem_rd);
    end
    checkOutput("hold_ready0", ready0, 1);
    checkOutput("hold_rdata0", rdata0, 16'h5555);
    @(posedge clk);
    #1 rd0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      readCount += int'(mem_rd);
    end
    checkOutput("hold_single_read", readCount, 1);
    checkOutput("hold_no_second_ready", {ready0, ready1}, 0);

    $display("[TB] reset during ACCESS");
    setReq(1, 1'b0, 1'b1, 16'h0030, 16'h7777);
    @(negedge clk);
    checkOutput("abort_mem_wr_before", mem_wr, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_mem_wr_async", mem_wr, 0);
    checkOutput("abort_outputs", {rdata0, rdata1, mem_addr, mem_wdata, mem_rd, ready0, ready1}, 0);
    checkOutput("abort_last", last, 1);
    setReq(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_ready1", ready1, 0);
    end
    checkOutput("abort_ram_untouched", ram[16'h0030], 16'h0000);
    rst = 1'b0;
    applyStimulus('{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hBEEF});

    $display("[TB] continuous demand from both cores");
    rst = 1'b1;
    @(negedge clk);
    setReq(0, 1'b1, 1'b0, 16'h0001, 16'h0);
    setReq(1, 1'b1, 1'b0, 16'h0002, 16'h0);
    rst = 1'b0;
    for (n = 1; n <= 18; n++) begin
      @(negedge clk);
      checkOutput("alt_ready0", ready0, (n % 6 == 3));
      checkOutput("alt_ready1", ready1, (n % 6 == 0));
      checkOutput("alt_mem_rd", mem_rd, (n % 3 == 1));
      checkOutput("alt_last", last, ((n - 1) / 3) % 2);
      if (n % 3 == 1) checkOutput("alt_mem_addr", mem_addr, (n % 6 == 1) ? 16'h0001 : 16'h0002);
      if (ready0) checkOutput("alt_rdata0", rdata0, 16'hAAAA);
      if (ready1) checkOutput("alt_rdata1", rdata1, 16'h5555);
    end
    setReq(0, 1'b0, 1'b0, 16'h0, 16'h0);
    setReq(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (4) @(negedge clk);

    $display("[TB] randomized two-core traffic");
    for (int i = 0; i < 8; i++) shadow[i] = 16'h0;
    lastRd[0] = 16'hAAAA;
    lastRd[1] = 16'h5555;
    fork
      begin
        fork
          coreRun(0, 40);
          coreRun(1, 40);
        join
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(negedge clk);
          checkOutput("excl_strobes", mem_rd & mem_wr, 0);
          checkOutput("excl_ready", ready0 & ready1, 0);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the data-memory accesses of the two cores onto one single-port synchronous data RAM.
- Sits between the two core data ports (DMADDR/DOUT/DIN/MEMREAD/MEMWR per core) and the data RAM.
- Serves one transaction at a time under round-robin priority and returns read data plus a one-cycle ready pulse to the requesting core.
- Cores hold their request stable until they see ready.

Parameters:
ADDR_W, 16, address width of core and RAM ports
DATA_W, 16, data width of core and RAM ports

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
rd0  in  1  core0 read request (MEMREAD)
wr0  in  1  core0 write request (MEMWR)
addr0  in  ADDR_W  core0 address (DMADDR)
wdata0  in  DATA_W  core0 write data (DOUT)
rdata0  out  DATA_W  core0 read data (DIN), registered
ready0  out  1  core0 transaction-complete pulse, registered
rd1, wr1, addr1, wdata1, rdata1, ready1  same as core0, for core1
mem_addr  out  ADDR_W  RAM address, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_rd  out  1  RAM read strobe, registered
mem_wr  out  1  RAM write strobe, registered
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_rd
last  out  1  index of the most recently granted core (debug)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While rst=1, every output is 0 except last=1, state is IDLE, and any in-flight transaction is dropped with no ready; the core must reissue it.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE (RESP can go straight to ACCESS).
- Request: reqX = rdX | wrX. If rdX and wrX are both high, the transaction is a write; the read is ignored.
- IDLE / RESP sampling, at each rising edge:
  - Candidates are the cores with a request.
  - In RESP, the core being served is excluded, because its request line is still high during its own ready cycle.
  - One candidate: grant it.
  - Two candidates: grant the core that is not last.
  - Grant latches g=index, addr, wdata and op into registers and sets last=g. Next state is ACCESS.
  - No candidate: go to IDLE.
- ACCESS (one cycle): mem_addr/mem_wdata driven from the latches; mem_rd=1 for a read, mem_wr=1 for a write. Next state is WAIT.
- WAIT (one cycle): mem_rd=mem_wr=0. On the closing edge, rdata_g <= mem_rdata for a read; writes leave rdata unchanged. Next state is RESP.
- RESP (one cycle): ready_g=1 and the other core's ready=0. Sampling of the next request happens on the closing edge.
- Latency: request sampled at edge E -> RAM strobe during cycle E+1 -> ready during cycle E+3.
- Throughput: one transaction per 3 cycles under continuous demand.
- rdataX holds its value until the next read completes for core X.
- The ungranted core waits with ready low. It is served next, at the latest after one transaction by the other core (no starvation).
- A request dropped before its grant is simply not served.
- Request inputs changing while the core is granted have no effect; the transaction uses the latched values.
- mem_rd and mem_wr are never high together, and never high outside ACCESS.
- Reset asserted in any state aborts the transaction immediately (asynchronous). mem_wr drops even mid-ACCESS.
- No address decode or range checks; addresses wrap naturally at ADDR_W bits.

Test Plan:
- Reset, then core0 write addr=0x0010 data=0xBEEF -> mem_wr=1 with mem_addr=0x0010 and mem_wdata=0xBEEF in cycle E+1; ready0=1 in E+3; ready1 stays 0; last=0.
- Core1 read addr=0x0010 with a RAM model -> mem_rd=1 in E+1; rdata1=0xBEEF and ready1=1 in E+3; rdata0 unchanged.
- Both cores read continuously from reset (core0 addr=0x1, core1 addr=0x2) -> grants alternate 0,1,0,1; each ready is 6 cycles apart; no grant twice in a row while the other core waits.
- Core0 asserts rd0 and wr0 together, addr=0x0020 data=0x1234 -> write only; mem_rd never asserts; RAM[0x20]=0x1234.
- Core0 holds rd0 high one extra cycle after ready0 (drops it at the edge ending RESP) -> exactly one transaction performed; no duplicate mem_rd.
- rst pulsed during ACCESS of a core1 write -> mem_wr falls asynchronously; ready1 never pulses; all outputs 0 and last=1; a fresh request after reset completes normally.
